// File: rtl/system_acl_iface_led_sched.sv
// -----------------------------------------------------------------------------
// system_acl_iface_led_sched
//
// Purpose: schedules LED updates from three sources (host, status logic and a
// free-running heartbeat) onto the single write port of an LED PIO, and keeps
// a shadow copy of the value last written so partial (masked) updates can be
// merged without reading the PIO back.
//
// Ports:
//   clk, reset                  sole clock, synchronous active-high reset
//   host_req/data/mask, host_ack  host update handshake (req held until ack)
//   stat_req/data/mask, stat_ack  status update handshake (req held until ack)
//   hb_enable                   heartbeat engine enable
//   avm_*                       PIO write port (address always 0)
//   led_shadow                  mirror of the last value written to the PIO
//   busy                        high while a write/ack sequence is in progress
//
// FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | round-robin arbitration; latch grant and merged LED value
//   ST_WRITE | one-cycle PIO write of the merged value; shadow updates
//   ST_ACK   | ack pulse to host/stat, or retire the pending heartbeat
// -----------------------------------------------------------------------------
module system_acl_iface_led_sched #(
    parameter int LED_W    = 7,
    parameter int TICK_DIV = 50000000,
    parameter int HB_BIT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_req,
    input  logic [LED_W-1:0] host_data,
    input  logic [LED_W-1:0] host_mask,
    output logic             host_ack,
    input  logic             stat_req,
    input  logic [LED_W-1:0] stat_data,
    input  logic [LED_W-1:0] stat_mask,
    output logic             stat_ack,
    input  logic             hb_enable,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    output logic [LED_W-1:0] led_shadow,
    output logic             busy
);

    localparam int                 CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LED_W-1:0]   HB_MASK  = LED_W'(1) << HB_BIT;
    localparam logic [1:0]         SRC_HOST = 2'd0;
    localparam logic [1:0]         SRC_STAT = 2'd1;
    localparam logic [1:0]         SRC_HB   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [LED_W-1:0]   merged_q, merged_d;
    logic [LED_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hb_pending_q, hb_pending_d;

    logic [2:0]         req;
    logic [1:0]         sel;
    logic [LED_W-1:0]   sel_data;
    logic [LED_W-1:0]   sel_mask;
    logic               hb_tick;
    logic               hb_clear;

    assign req = {hb_pending_q, stat_req, host_req};

    // Round-robin: search starts at the source after the last one granted.
    always_comb begin
        sel = SRC_HOST;
        case (last_grant_q)
            SRC_HOST: begin
                if (req[1])      sel = SRC_STAT;
                else if (req[2]) sel = SRC_HB;
                else             sel = SRC_HOST;
            end
            SRC_STAT: begin
                if (req[2])      sel = SRC_HB;
                else if (req[0]) sel = SRC_HOST;
                else             sel = SRC_STAT;
            end
            default: begin
                if (req[0])      sel = SRC_HOST;
                else if (req[1]) sel = SRC_STAT;
                else             sel = SRC_HB;
            end
        endcase
    end

    // Heartbeat data is the inverted shadow; the mask confines it to HB_BIT.
    always_comb begin
        sel_data = ~shadow_q;
        sel_mask = HB_MASK;
        case (sel)
            SRC_HOST: begin
                sel_data = host_data;
                sel_mask = host_mask;
            end
            SRC_STAT: begin
                sel_data = stat_data;
                sel_mask = stat_mask;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        merged_d       = merged_q;
        shadow_d       = shadow_q;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 32'd0;
        host_ack       = 1'b0;
        stat_ack       = 1'b0;
        hb_clear       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d      = ST_WRITE;
                    grant_d      = sel;
                    last_grant_d = sel;
                    merged_d     = (shadow_q & ~sel_mask) | (sel_data & sel_mask);
                end
            end
            ST_WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = 32'(merged_q);
                shadow_d       = merged_q;
                state_d        = ST_ACK;
            end
            ST_ACK: begin
                host_ack = (grant_q == SRC_HOST);
                stat_ack = (grant_q == SRC_STAT);
                hb_clear = (grant_q == SRC_HB);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A tick in the same cycle as the heartbeat ack keeps the request pending;
    // further ticks while pending simply coalesce into it.
    assign hb_tick = hb_enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d        = '0;
        hb_pending_d = 1'b0;
        if (hb_enable) begin
            cnt_d        = hb_tick ? '0 : cnt_q + CNT_W'(1);
            hb_pending_d = hb_tick | (hb_pending_q & ~hb_clear);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= SRC_HOST;
            last_grant_q <= SRC_HB;
            merged_q     <= '1;
            shadow_q     <= '1;
            cnt_q        <= '0;
            hb_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            merged_q     <= merged_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            hb_pending_q <= hb_pending_d;
        end
    end

    assign avm_address = 2'b00;
    assign led_shadow  = shadow_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/system_acl_iface_led_sched.md
SYSTEM_ACL_IFACE_LED_SCHED -- requirements
Module: system_acl_iface_led_sched

Interface
REQ-001 SHALL provide parameters, one per line:
- LED_W, 7, LED width, matching the LED PIO out_port.
- TICK_DIV, 50000000, heartbeat period in clk cycles (>=2).
- HB_BIT, 0, LED index toggled by the heartbeat (< LED_W).
REQ-002 SHALL provide ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- host_req  in  1  host update request, held until host_ack.
- host_data  in  LED_W  host LED values.
- host_mask  in  LED_W  host bits to update (1 = update).
- host_ack  out  1  one-cycle completion pulse for the host request.
- stat_req  in  1  status-logic update request, held until stat_ack.
- stat_data  in  LED_W  status LED values.
- stat_mask  in  LED_W  status bits to update.
- stat_ack  out  1  one-cycle completion pulse for the status request.
- hb_enable  in  1  heartbeat engine enable.
- avm_address  out  2  PIO address, always 0.
- avm_chipselect  out  1  PIO chip select.
- avm_write_n  out  1  PIO write strobe, active low.
- avm_writedata  out  32  PIO write data; bits [31:LED_W] are 0.
- led_shadow  out  LED_W  mirror of the value last written to the PIO.
- busy  out  1  high when FSM is not IDLE.

Function
REQ-003 SHALL arbitrate three sources onto the single-master PIO write port: host (index 0), stat (index 1), heartbeat (index 2).
REQ-004 SHALL keep led_shadow; reset value = all ones (127 for LED_W=7), equal to the PIO reset value.
REQ-005 SHALL merge per grant: new = (led_shadow & ~mask) | (data & mask).
REQ-006 Heartbeat request SHALL use mask = 1<<HB_BIT and data = ~led_shadow[HB_BIT] at that bit.
REQ-007 SHALL run a heartbeat counter 0..TICK_DIV-1 while hb_enable=1; on the wrap cycle it SHALL set hb_pending.
REQ-008 A tick while hb_pending=1 SHALL be coalesced (no queueing, no error).
REQ-009 hb_enable=0 SHALL hold the counter at 0 and clear hb_pending; an in-flight heartbeat grant still completes.
REQ-010 FSM states SHALL be IDLE, WRITE, ACK; IDLE->WRITE when any request is pending; WRITE->ACK unconditionally; ACK->IDLE unconditionally.
REQ-011 In IDLE SHALL grant round-robin starting after last_grant (reset last_grant=2, so host wins first); latch grant index and merged value.
REQ-012 In WRITE (exactly one cycle) SHALL drive avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata={0,merged}; led_shadow SHALL update at the end of this cycle.
REQ-013 Outside WRITE SHALL drive avm_chipselect=0, avm_write_n=1, avm_writedata=0.
REQ-014 In ACK SHALL pulse host_ack or stat_ack for a host or stat grant, or clear hb_pending for a heartbeat grant; exactly one ack per grant.
REQ-015 Latency SHALL be: request seen in IDLE at cycle N, write at N+1, ack at N+2, next arbitration at N+3; throughput 1 write per 3 cycles.
REQ-016 A req deasserted after grant SHALL still complete with the latched data; a req still high after its ack SHALL be treated as a new request.
REQ-017 mask=0 SHALL still perform the PIO write (value unchanged) and ack.
REQ-018 A heartbeat tick coinciding with a heartbeat ACK SHALL leave hb_pending=1 (set wins over clear).
REQ-019 busy SHALL be 1 in WRITE and ACK and 0 in IDLE.

Reset
REQ-020 reset=1 SHALL, at the next edge regardless of state, force: IDLE, chipselect=0, write_n=1, writedata=0, acks=0, led_shadow=all ones, counter=0, hb_pending=0, last_grant=2.
REQ-021 A write interrupted by reset SHALL NOT produce an ack; led_shadow SHALL read all ones after reset.

Verification
REQ-022 Reset, then host_req with data=0x00 and mask=0x7F -> chipselect one cycle later with writedata=0x00, host_ack one cycle after that, led_shadow=0x00.
REQ-023 host_req and stat_req high together, both held -> order host, stat, host, stat; writes 3 cycles apart; each ack is a single-cycle pulse.
REQ-024 TICK_DIV=4, hb_enable=1, shadow=0x7F -> write 0x7E, then 0x7F, repeating every 4 cycles (while not blocked); hb_enable=0 -> writes stop.
REQ-025 host mask=0x05, data=0x00 on shadow=0x7F -> write 0x7A; mask=0 -> write 0x7A again, ack given.
REQ-026 reset asserted during WRITE -> no ack, chipselect=0 next cycle, led_shadow=0x7F.
